// File: rtl/frida_pkg.sv
// Shared constants for the comparator-output path: mode codes, packet FSM
// state encoding and the default packet header.
package frida_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC = 2'd0;
    localparam mode_t MODE_SCAN   = 2'd1;
    localparam mode_t MODE_PACKET = 2'd2;
    localparam mode_t MODE_OFF    = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [3:0] HDR_DEFAULT = 4'b1010;

endpackage

// File: rtl/rr_next_enabled.sv
// Combinational wrap-around priority finder: first set bit of ch_en at or
// after ptr, searching upward and wrapping to index 0.
module rr_next_enabled #(
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  ch_en,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_CH-1:0] rotated;
    int              sum;

    // Bit i of rotated corresponds to channel (ptr + i) mod N_CH.
    assign rotated = N_CH'({ch_en, ch_en} >> ptr);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found = 1'b1;
                sum   = int'(ptr) + i;
                if (sum >= N_CH) begin
                    sum = sum - N_CH;
                end
                idx = SEL_W'(sum);
            end
        end
    end

endmodule

// File: rtl/comp_out_seq_mux.sv
// Comparator-output multiplexer driving the single LVDS TX data pad in
// STATIC, SCAN (round-robin) or PACKET (header + all channels) mode.
module comp_out_seq_mux
    import frida_pkg::*;
#(
    parameter int              N_CH  = 16,
    parameter int              SEL_W = $clog2(N_CH),
    parameter int              HDR_W = 4,
    parameter logic [HDR_W-1:0] HDR  = HDR_W'(HDR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] static_sel,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             cmp_strobe,
    input  logic [N_CH-1:0]  cmp_in,
    input  logic             clr_overrun,
    output logic             comp_out,
    output logic             comp_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(N_CH + HDR_W);

    mode_t            mode_q;
    logic [1:0]       state_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [N_CH-1:0]  shadow_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic             out_reg;
    logic             valid_reg;
    logic             fs_reg;
    logic             overrun_reg;

    logic [SEL_W-1:0] scan_idx;
    logic             scan_found;
    logic [SEL_W-1:0] low_idx;
    logic             low_found;
    logic [SEL_W-1:0] ptr_next;
    logic             static_bit;
    logic [HDR_W-1:0] hdr_mask;
    logic             hdr_bit;
    logic             data_bit;
    logic             pkt_bit;
    logic             hdr_last;
    logic             last_data;
    logic             pkt_accept;
    logic             pkt_drop;

    rr_next_enabled #(.N_CH(N_CH), .SEL_W(SEL_W)) u_scan_find (
        .ch_en (ch_en),
        .ptr   (ptr_reg),
        .idx   (scan_idx),
        .found (scan_found)
    );

    rr_next_enabled #(.N_CH(N_CH), .SEL_W(SEL_W)) u_low_find (
        .ch_en (ch_en),
        .ptr   ('0),
        .idx   (low_idx),
        .found (low_found)
    );

    assign ptr_next   = (int'(scan_idx) == N_CH - 1) ? '0 : scan_idx + SEL_W'(1);
    assign static_bit = (int'(static_sel) < N_CH) ? cmp_in[static_sel] : 1'b0;

    assign hdr_mask = (HDR_W'(1) << (HDR_W - 1)) >> bit_cnt_reg;
    assign hdr_bit  = |(HDR & hdr_mask);
    assign data_bit = shadow_reg[bit_cnt_reg[SEL_W-1:0]];
    assign pkt_bit  = (state_reg == ST_HDR) ? hdr_bit : data_bit;

    assign hdr_last  = (state_reg == ST_HDR)  && (bit_cnt_reg == CNT_W'(HDR_W - 1));
    assign last_data = (state_reg == ST_DATA) && (bit_cnt_reg == CNT_W'(N_CH - 1));

    // A strobe in the final data cycle chains straight into the next packet.
    assign pkt_accept = cmp_strobe && (mode_q == MODE_PACKET) &&
                        ((state_reg == ST_IDLE) || last_data);
    assign pkt_drop   = cmp_strobe && (state_reg != ST_IDLE) && !last_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shadow_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pkt_accept) begin
                        state_reg   <= ST_HDR;
                        bit_cnt_reg <= '0;
                        shadow_reg  <= cmp_in & ch_en;
                    end
                end
                ST_HDR: begin
                    if (hdr_last) begin
                        state_reg   <= ST_DATA;
                        bit_cnt_reg <= '0;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (last_data) begin
                        bit_cnt_reg <= '0;
                        if (pkt_accept) begin
                            state_reg  <= ST_HDR;
                            shadow_reg <= cmp_in & ch_en;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Mode is frozen for the whole packet and picked up again as it ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_OFF;
        end else if ((state_reg == ST_IDLE) || (last_data && !pkt_accept)) begin
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= 1'b0;
            valid_reg <= 1'b0;
            fs_reg    <= 1'b0;
            ptr_reg   <= '0;
        end else begin
            out_reg   <= 1'b0;
            valid_reg <= 1'b0;
            fs_reg    <= 1'b0;
            case (mode_q)
                MODE_STATIC: begin
                    out_reg   <= static_bit;
                    valid_reg <= cmp_strobe;
                    fs_reg    <= cmp_strobe;
                end
                MODE_SCAN: begin
                    if (cmp_strobe && scan_found) begin
                        out_reg   <= cmp_in[scan_idx];
                        valid_reg <= 1'b1;
                        fs_reg    <= low_found && (scan_idx == low_idx);
                        ptr_reg   <= ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_reg <= 1'b0;
        end else if (pkt_drop) begin
            overrun_reg <= 1'b1;
        end else if (clr_overrun) begin
            overrun_reg <= 1'b0;
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign comp_out    = busy ? pkt_bit : out_reg;
    assign comp_valid  = busy | valid_reg;
    assign frame_start = busy ? ((state_reg == ST_HDR) && (bit_cnt_reg == '0)) : fs_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_comp_out_seq_mux.sv
// Scoreboard bench: stimulus pushes expected serial bits, a negedge monitor
// pops and compares whenever comp_valid is high.
module tb_comp_out_seq_mux;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  static_sel;
    logic [15:0] ch_en;
    logic        cmp_strobe;
    logic [15:0] cmp_in;
    logic        clr_overrun;
    logic        comp_out;
    logic        comp_valid;
    logic        frame_start;
    logic        busy;
    logic        overrun;

    typedef struct packed {
        logic bit_v;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    comp_out_seq_mux dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .static_sel  (static_sel),
        .ch_en       (ch_en),
        .cmp_strobe  (cmp_strobe),
        .cmp_in      (cmp_in),
        .clr_overrun (clr_overrun),
        .comp_out    (comp_out),
        .comp_valid  (comp_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_strobe();
        cmp_strobe = 1'b1;
        tick();
        cmp_strobe = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push_bit(input logic b, input logic fs);
        exp_t e;
        e.bit_v = b;
        e.fs    = fs;
        exp_q.push_back(e);
    endtask

    // Header 1010 MSB first, then data bits 0 upward; n entries in total.
    task automatic push_packet(input logic [15:0] data, input int n);
        logic [3:0] hdr_pat;
        hdr_pat = 4'b1010;
        for (int k = 0; k < n; k++) begin
            if (k < 4) push_bit(hdr_pat[3-k], k == 0);
            else       push_bit(data[k-4], 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (comp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got comp_out=%b frame_start=%b expected no output",
                         comp_out, frame_start);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (comp_out !== e.bit_v || frame_start !== e.fs) begin
                    errors++;
                    $display("FAIL serial_bit: got comp_out=%b frame_start=%b expected %b/%b",
                             comp_out, frame_start, e.bit_v, e.fs);
                end else begin
                    $display("ok   serial_bit: comp_out=%b frame_start=%b", comp_out, frame_start);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        mode        = 2'd3;
        static_sel  = '0;
        ch_en       = '0;
        cmp_strobe  = 1'b0;
        cmp_in      = '0;
        clr_overrun = 1'b0;
        repeat (3) tick();
        check("rst_comp_out", comp_out, 0);
        check("rst_comp_valid", comp_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // STATIC
        mode = 2'd0; static_sel = 4'd5; cmp_in = 16'h0020;
        tick();
        push_bit(1'b1, 1'b1);
        do_strobe();
        tick();
        check("static_valid_drop", comp_valid, 0);
        static_sel = 4'd4;
        push_bit(1'b0, 1'b1);
        do_strobe();
        tick();

        // SCAN over channels 0,2,4
        mode = 2'd1; ch_en = 16'h0015; cmp_in = 16'h0004;
        tick();
        push_bit(1'b0, 1'b1); do_strobe(); tick();
        push_bit(1'b1, 1'b0); do_strobe(); tick();
        push_bit(1'b0, 1'b0); do_strobe(); tick();
        push_bit(1'b0, 1'b1); do_strobe(); tick();
        ch_en = 16'h0000;
        do_strobe();
        check("scan_none_valid", comp_valid, 0);
        do_strobe();
        check("scan_none_valid2", comp_valid, 0);
        tick();
        ch_en = 16'h8000; cmp_in = 16'h8000;
        push_bit(1'b1, 1'b1);
        do_strobe();
        tick();

        // PACKET, back-to-back, overrun handling
        mode = 2'd2; ch_en = 16'hFFFF; cmp_in = 16'h8001;
        tick();
        check("pkt_idle_busy", busy, 0);
        push_packet(16'h8001, 20);
        do_strobe();
        for (int i = 1; i < 20; i++) begin
            check("pkt_busy", busy, 1);
            tick();
        end
        check("pkt_busy_last", busy, 1);
        cmp_in = 16'h00F0;
        push_packet(16'h00F0, 20);
        do_strobe();
        check("b2b_busy", busy, 1);
        check("b2b_no_overrun", overrun, 0);
        repeat (9) tick();
        cmp_in = 16'hFFFF;
        do_strobe();
        check("overrun_set", overrun, 1);
        clr_overrun = 1'b1; cmp_strobe = 1'b1;
        tick();
        cmp_strobe = 1'b0; clr_overrun = 1'b0;
        check("overrun_set_priority", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("overrun_clear", overrun, 0);
        repeat (8) tick();
        check("pkt_end_busy", busy, 0);

        // Reset mid-packet
        cmp_in = 16'hFFFF;
        push_packet(16'hFFFF, 8);
        do_strobe();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", comp_valid, 0);
        check("abort_frame_start", frame_start, 0);
        rst = 1'b0;
        tick();

        // Mode change while busy applies only after the packet
        cmp_in = 16'h0003;
        push_packet(16'h0003, 20);
        do_strobe();
        tick();
        mode = 2'd0; static_sel = 4'd1;
        repeat (18) tick();
        check("modechg_busy_last", busy, 1);
        tick();
        check("modechg_idle", busy, 0);
        cmp_in = 16'h0002;
        push_bit(1'b1, 1'b1);
        do_strobe();
        repeat (3) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_out_seq_mux.md
Name: comp_out_seq_mux

Overview:
- Parametrised successor to the fixed 16:1 comparator-output multiplexer feeding the single LVDS TX data pad.
- Takes N_CH comparator decisions and drives one serial output, in one of three modes:
  - STATIC: one selected channel.
  - SCAN: round-robin over enabled channels, one channel per decision strobe.
  - PACKET: all channels serialized behind a header.
- Sits in frida_core between the ADC array and the comp_out net; mode, select and enables come from the SPI configuration register.

Parameters:
- N_CH, 16, number of ADC comparator channels (2..64).
- SEL_W, $clog2(N_CH), width of channel select.
- HDR_W, 4, packet header length in bits.
- HDR, 4'b1010, packet header pattern, MSB sent first.

Ports:
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0=STATIC, 1=SCAN, 2=PACKET, 3=OFF.
- static_sel  in  SEL_W  channel index for STATIC.
- ch_en  in  N_CH  per-channel enable for SCAN and PACKET.
- cmp_strobe  in  1  one-cycle pulse: cmp_in valid this cycle.
- cmp_in  in  N_CH  comparator decisions, bit i = ADC i.
- clr_overrun  in  1  clears the overrun flag.
- comp_out  out  1  serial data to LVDS TX.
- comp_valid  out  1  comp_out carries a valid bit this cycle.
- frame_start  out  1  first bit of a scan round or packet.
- busy  out  1  PACKET serialization in progress.
- overrun  out  1  sticky: strobe lost while busy.

Behaviour:
- Reset: comp_out, comp_valid, frame_start, busy and overrun = 0; scan pointer = 0; FSM = IDLE.
- Mode latching:
  - Mode is latched into mode_q only in IDLE.
  - Changes while busy take effect one cycle after the packet ends.
  - In STATIC, SCAN and OFF, mode_q follows mode every cycle.
- STATIC:
  - comp_out <= cmp_in[static_sel]; comp_valid <= cmp_strobe (1-cycle latency).
  - frame_start <= cmp_strobe.
  - static_sel >= N_CH yields comp_out 0.
- SCAN:
  - On cmp_strobe, ch = first enabled index at or after ptr, searching with wrap-around.
  - Next cycle: comp_out = cmp_in[ch] (captured at strobe), comp_valid = 1, frame_start = (ch == lowest enabled index).
  - ptr <= (ch+1) mod N_CH.
  - ch_en == 0: no comp_valid, ptr unchanged, comp_out 0.
  - ch_en changes take effect at the next strobe.
- PACKET FSM (IDLE -> HDR -> DATA -> IDLE):
  - IDLE: on cmp_strobe, shadow <= cmp_in & ch_en, bit_cnt <= 0, go to HDR, busy = 1.
  - HDR: emit HDR MSB-first, one bit/cycle, comp_valid = 1; frame_start on the first header bit.
  - DATA: emit shadow[0]..shadow[N_CH-1], one bit/cycle; disabled channels send 0.
  - Latency: first header bit appears 1 cycle after the strobe. Packet length = HDR_W + N_CH cycles (20 for defaults).
  - cmp_strobe in the last DATA cycle is accepted: the new packet's first header bit follows with no gap.
  - cmp_strobe while busy at any other time: strobe dropped, overrun <= 1.
  - busy deasserts in the cycle after the last data bit unless a back-to-back packet starts.
- OFF: all outputs 0 except overrun; ptr held.
- overrun:
  - Set has priority over clr_overrun in the same cycle.
  - Cleared only by clr_overrun or rst.
- rst mid-packet: abort immediately; outputs return to reset values next cycle; shadow discarded.

Decomposition:
- Shared package frida_pkg holds:
  - MODE_STATIC/MODE_SCAN/MODE_PACKET/MODE_OFF constants.
  - FSM state encoding.
  - Default HDR pattern.
- Sub-module rr_next_enabled: combinational wrap-around priority finder.
  - Inputs: ch_en, ptr. Outputs: idx, found.
  - Also reused for the lowest-enabled search with ptr = 0.

Test Plan:
- STATIC, static_sel=5, cmp_in=16'h0020, strobe cycle t -> comp_out=1, comp_valid=1 at t+1; static_sel=4 -> comp_out=0.
- SCAN, ch_en=16'h0015 (ch 0,2,4), cmp_in=16'h0004, 4 strobes -> channels 0,2,4,0 output bits 0,1,0,0; frame_start on 1st and 4th.
- SCAN, ch_en=0, strobes -> comp_valid stays 0, ptr unchanged; then ch_en=16'h8000 -> channel 15 output on next strobe.
- PACKET, ch_en=16'hFFFF, cmp_in=16'h8001:
  - strobe at t -> t+1..t+4 = 1,0,1,0; t+5 = 1; t+6..t+19 = 0; t+20 = 1; busy high t+1..t+20.
  - Second strobe at t+20 -> header restarts at t+21, no overrun.
- PACKET, strobe at t+10 while busy -> overrun=1, packet unchanged.
  - clr_overrun and a new overrun event in the same cycle -> overrun stays 1.
  - clr_overrun alone -> overrun=0.
- rst asserted at t+8 mid-packet -> at t+9 busy=0, comp_valid=0; mode change during packet applied only after packet end.
